// File: rtl/clk_div_monitor.sv
// Consumer-side checker for the /4 and /8 clocks derived from clk_8f: half-period and
// rise-alignment checks, lock tracking over clean clk_f periods, saturating error count.
module clk_div_monitor #(
  parameter int LOCK_CNT = 2,
  parameter int ERRW     = 8
) (
  input  logic            clk_8f,
  input  logic            rst,
  input  logic            enb,
  input  logic            clk_2f_in,
  input  logic            clk_f_in,
  output logic            locked,
  output logic            err_2f,
  output logic            err_f,
  output logic            err_phase,
  output logic [ERRW-1:0] err_count
);
  localparam logic [2:0]      HALF2     = 3'd2;
  localparam logic [3:0]      HALFF     = 4'd4;
  localparam logic [3:0]      GOOD_LAST = 4'(LOCK_CNT - 1);
  localparam logic [ERRW-1:0] CNT_ONE   = {{(ERRW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ACQUIRE, CHECK, LOCKED} state_e;
  state_e state_q, state_d;

  logic            s2_q, s2p_q, sf_q, sfp_q;
  logic [2:0]      r2_q, r2_d;
  logic [3:0]      rf_q, rf_d;
  logic [3:0]      good_q, good_d;
  logic            e2_q, ef_q, ep_q;
  logic [ERRW-1:0] cnt_q, cnt_d;
  logic            t2, tf, rise2, risef, active, start, e2, ef, ep, any_err;

  assign t2     = s2_q ^ s2p_q;
  assign tf     = sf_q ^ sfp_q;
  assign rise2  = s2_q & ~s2p_q;
  assign risef  = sf_q & ~sfp_q;
  assign active = enb && (state_q == CHECK || state_q == LOCKED);
  assign start  = enb && (state_q == ACQUIRE) && risef;

  // A missing edge is flagged once when the run reaches HALF; runs beyond that sit
  // saturated above HALF, so neither they nor the edge that ends them flag again.
  assign e2      = active && (t2 ? (r2_q < HALF2) : (r2_q == HALF2));
  assign ef      = active && (tf ? (rf_q < HALFF) : (rf_q == HALFF));
  assign ep      = active && risef && !rise2;
  assign any_err = e2 || ef || ep;

  always_comb begin
    r2_d = (r2_q == HALF2 + 3'd1) ? r2_q : r2_q + 3'd1;
    rf_d = (rf_q == HALFF + 4'd1) ? rf_q : rf_q + 4'd1;
    if (t2 || start) r2_d = 3'd1;
    if (tf || start) rf_d = 4'd1;
  end

  always_comb begin
    good_d = good_q;
    if (start || any_err)                         good_d = '0;
    else if (enb && state_q == CHECK && risef)    good_d = good_q + 4'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (any_err && cnt_q != {ERRW{1'b1}}) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_8f) begin
    if (rst) begin
      s2_q   <= 1'b0;
      s2p_q  <= 1'b0;
      sf_q   <= 1'b0;
      sfp_q  <= 1'b0;
      r2_q   <= '0;
      rf_q   <= '0;
      good_q <= '0;
      e2_q   <= 1'b0;
      ef_q   <= 1'b0;
      ep_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s2_q   <= clk_2f_in;
      s2p_q  <= s2_q;
      sf_q   <= clk_f_in;
      sfp_q  <= sf_q;
      r2_q   <= r2_d;
      rf_q   <= rf_d;
      good_q <= good_d;
      e2_q   <= e2;
      ef_q   <= ef;
      ep_q   <= ep;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_8f) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enb) state_d = IDLE;
    else begin
      unique case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (risef) state_d = CHECK;
        CHECK: begin
          if (any_err)                             state_d = ACQUIRE;
          else if (risef && good_q == GOOD_LAST)   state_d = LOCKED;
        end
        LOCKED:  if (any_err) state_d = ACQUIRE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    locked    = (state_q == LOCKED);
    err_2f    = e2_q;
    err_f     = ef_q;
    err_phase = ep_q;
    err_count = cnt_q;
  end
endmodule
